// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and helpers for the register file slice
package reg_file_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned POP_MAX_W  = 64;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;

  function automatic int unsigned pc_idx(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - write/link/issue/read bundle of the register file
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3
);
  logic                     reg_write;
  logic [ADDR_W-1:0]        write_addr;
  logic [DATA_W-1:0]        write_data;
  logic                     link;
  logic [DATA_W-1:0]        pc_content;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_addr;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     pc_write;
  logic [2**ADDR_W-1:0]     busy_vec;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output reg_write, write_addr, write_data, link, pc_content,
    output issue_valid, issue_addr, rd_addr,
    input  rd_data, rd_busy, pc_write, busy_vec, busy_cnt
  );

  modport slave (
    input  reg_write, write_addr, write_data, link, pc_content,
    input  issue_valid, issue_addr, rd_addr,
    output rd_data, rd_busy, pc_write, busy_vec, busy_cnt
  );
endinterface

// File: rtl/reg_sb_busy.sv
// rtl/reg_sb_busy.sv - pending-write scoreboard bits and their population count
module reg_sb_busy
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int LINK_IDX = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_addr,
  input  logic                 reg_write,
  input  logic [ADDR_W-1:0]    write_addr,
  input  logic                 link,
  output logic [2**ADDR_W-1:0] busy_vec,
  output logic [ADDR_W:0]      busy_cnt
);
  localparam int unsigned NREG   = 2**ADDR_W;
  localparam int unsigned PC_IDX = pc_idx(ADDR_W);

  logic [NREG-1:0]      busy_q, busy_d;
  logic [POP_MAX_W-1:0] pop_in;
  int unsigned          pop_n;

  // A new producer issued this cycle outranks the retiring write of the old one.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < PC_IDX; r++) begin
      if (issue_valid && issue_addr == ADDR_W'(r)) begin
        busy_d[r] = 1'b1;
      end else if ((reg_write && write_addr == ADDR_W'(r)) || (link && r == LINK_IDX)) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[PC_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    pop_in            = '0;
    pop_in[NREG-1:0]  = busy_q;
    pop_n             = popcount(pop_in);
    busy_cnt          = pop_n[ADDR_W:0];
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with PC alias, link write, bypass and scoreboard
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 3,
  parameter int LINK_IDX = 14
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave bus
);
  localparam int unsigned       NREG   = 2**ADDR_W;
  localparam int unsigned       PC_IDX = pc_idx(ADDR_W);
  localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_IDX);

  if (LINK_IDX < 0 || LINK_IDX >= PC_IDX) begin : g_bad_link
    $error("reg_file_sb: LINK_IDX must be below PC_IDX");
  end
  if (NUM_RD < 1 || ADDR_W > 6) begin : g_bad_shape
    $error("reg_file_sb: NUM_RD must be >= 1 and ADDR_W <= 6");
  end

  logic [DATA_W-1:0]        regs_q [PC_IDX];
  logic [DATA_W-1:0]        regs_d [PC_IDX];
  logic [NREG-1:0]          busy_w;
  logic [ADDR_W:0]          busy_cnt_w;
  logic [NUM_RD*DATA_W-1:0] rd_data_w;
  logic [NUM_RD-1:0]        rd_busy_w;

  // Link is applied last so it wins over a same-cycle write to LINK_IDX.
  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < PC_IDX; r++) begin
      if (bus.reg_write && bus.write_addr == ADDR_W'(r)) regs_d[r] = bus.write_data;
      if (bus.link && r == LINK_IDX)                     regs_d[r] = bus.pc_content;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < PC_IDX; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored, data;
    logic              hit_link, hit_wr;

    assign addr     = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign hit_link = bus.link && addr == LINK_A;
    assign hit_wr   = bus.reg_write && bus.write_addr == addr;

    always_comb begin
      stored = '0;
      for (int r = 0; r < PC_IDX; r++) begin
        if (addr == ADDR_W'(r)) stored = regs_q[r];
      end
    end

    always_comb begin
      data = stored;
      if (addr == PC_A)  data = bus.pc_content;
      else if (hit_link) data = bus.pc_content;
      else if (hit_wr)   data = bus.write_data;
    end

    assign rd_data_w[k*DATA_W +: DATA_W] = data;
    assign rd_busy_w[k] = busy_w[addr] && !hit_link && !hit_wr && addr != PC_A;
  end

  reg_sb_busy #(
    .ADDR_W   (ADDR_W),
    .LINK_IDX (LINK_IDX)
  ) u_busy (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (bus.issue_valid),
    .issue_addr  (bus.issue_addr),
    .reg_write   (bus.reg_write),
    .write_addr  (bus.write_addr),
    .link        (bus.link),
    .busy_vec    (busy_w),
    .busy_cnt    (busy_cnt_w)
  );

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_busy  = rd_busy_w;
  assign bus.busy_vec = busy_w;
  assign bus.busy_cnt = busy_cnt_w;
  assign bus.pc_write = bus.reg_write && bus.write_addr == PC_A;
endmodule
